// File: rtl/ro_bank_meter.sv
// ro_bank_meter: bank of gated ring oscillators with a clk-domain edge-count frequency meter
module cinv #(
  parameter int DLY = 0
) (
  input  logic a,
  output logic y
);
  // the delay only makes rings oscillate in simulation; synthesis drops it
  assign #(DLY) y = ~a;
endmodule

module ro_bank_meter #(
  parameter int N_RO     = 4,
  parameter int N_STAGES = 5,
  parameter int CNT_W    = 16,
  parameter int WIN_W    = 12,
  parameter int SETTLE   = 4,
  parameter int SYNC     = 3,
  parameter int BASE_PS  = 200,
  parameter int STEP_PS  = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [$clog2(N_RO)-1:0] sel,
  input  logic [WIN_W-1:0]        win_cycles,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        count,
  output logic                    ovf,
  output logic                    ro_out
);
  localparam int SW = $clog2(N_RO);
  if (N_STAGES % 2 == 0 || N_STAGES < 3) begin : g_bad_stages
    $error("N_STAGES must be odd and >= 3");
  end
  typedef enum logic [2:0] {IDLE, ARM, SETTLE_S, MEAS, STOP} state_t;
  state_t state, state_n;
  logic [WIN_W-1:0] timer, timer_n, win, win_n;
  logic [SW-1:0] sel_q, sel_n;
  logic [N_RO-1:0] en, en_n, g;
  logic cen, cen_n, clr, clr_n, done_n, ovf_n, aclr, s1, s2, rovf;
  logic [CNT_W-1:0] count_n, cnt;
  for (genvar r = 0; r < N_RO; r++) begin : ring
    (* keep *) logic o;
    (* keep *) logic st [N_STAGES];
    assign o    = en[r] & st[N_STAGES-1];
    assign g[r] = o;
    (* keep *) cinv #(.DLY(BASE_PS + r * STEP_PS)) u_inv0 (.a(o), .y(st[0]));
    for (genvar s = 1; s < N_STAGES; s++) begin : stage
      (* keep *) cinv #(.DLY(BASE_PS + r * STEP_PS)) u_inv (.a(st[s-1]), .y(st[s]));
    end
  end
  assign ro_out = g[sel_q];
  assign aclr   = rst | clr;
  assign busy   = state != IDLE;
  always_ff @(posedge ro_out or posedge aclr)
    if (aclr) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      rovf <= 1'b0;
    end else begin
      s1 <= cen;
      s2 <= s1;
      if (s2 && &cnt) rovf <= 1'b1;
      if (s2 && !(&cnt)) cnt <= cnt + 1'b1;
    end
  always_comb begin
    state_n = state;
    timer_n = timer;
    sel_n   = sel_q;
    win_n   = win;
    en_n    = en;
    cen_n   = cen;
    clr_n   = 1'b0;
    done_n  = 1'b0;
    count_n = count;
    ovf_n   = ovf;
    case (state)
      IDLE: if (start) begin
        state_n = ARM;
        sel_n   = int'(sel) < N_RO ? sel : '0;
        win_n   = win_cycles == '0 ? WIN_W'(1) : win_cycles;
        clr_n   = 1'b1;
        count_n = '0;
        ovf_n   = 1'b0;
      end
      ARM: begin
        state_n = SETTLE_S;
        en_n    = N_RO'(1) << sel_q;
        timer_n = WIN_W'(SETTLE - 1);
      end
      SETTLE_S: begin
        timer_n = timer == '0 ? win - 1'b1 : timer - 1'b1;
        cen_n   = timer == '0;
        state_n = timer == '0 ? MEAS : SETTLE_S;
      end
      MEAS: begin
        // the ring keeps running past the window so the sync pipeline drains
        timer_n = timer == '0 ? WIN_W'(SYNC + 2) : timer - 1'b1;
        cen_n   = timer != '0;
        state_n = timer == '0 ? STOP : MEAS;
      end
      STOP: begin
        timer_n = timer - 1'b1;
        en_n    = timer == WIN_W'(SYNC) ? '0 : en;
        if (timer == '0) begin
          state_n = IDLE;
          count_n = cnt;
          ovf_n   = rovf;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      sel_q <= '0;
      win   <= '0;
      en    <= '0;
      cen   <= 1'b0;
      clr   <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      sel_q <= sel_n;
      win   <= win_n;
      en    <= en_n;
      cen   <= cen_n;
      clr   <= clr_n;
      done  <= done_n;
      count <= count_n;
      ovf   <= ovf_n;
    end
endmodule

// File: tb/tb_ro_bank_meter.sv
// tb_ro_bank_meter: directed vectors for the ring-oscillator bank meter (clk 10 ns, rings 2/3/4/5 ns)
module tb_ro_bank_meter;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, start8 = 1'b0;
  logic [1:0] sel = '0;
  logic [11:0] win_cycles = '0;
  logic busy, done, ovf, ro_out, busy8, done8, ovf8, ro_out8;
  logic [15:0] count;
  logic [7:0] count8;
  int checks = 0, errors = 0;
  typedef struct {
    int b8, s, w, cnt, tol, ovf, lat;
  } vec_t;
  vec_t vecs [8];

  ro_bank_meter dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .win_cycles(win_cycles),
    .busy(busy), .done(done), .count(count), .ovf(ovf), .ro_out(ro_out)
  );
  ro_bank_meter #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sel(sel), .win_cycles(win_cycles),
    .busy(busy8), .done(done8), .count(count8), .ovf(ovf8), .ro_out(ro_out8)
  );

  always #5000 clk = ~clk;

  task automatic check(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic run(input int b8, input int s, input int w, output int lat, output int c,
                     output int o, output int bz, output int others, output int live);
    logic [3:0] mask;
    mask = 4'(1) << s;
    others = 0;
    @(negedge clk);
    sel = 2'(s);
    win_cycles = 12'(w);
    if (b8 != 0) start8 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start8 = 1'b0;
    bz = b8 != 0 ? int'(busy8) : int'(busy);
    lat = 0;
    while (!(b8 != 0 ? done8 : done) && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      others = others | int'((b8 != 0 ? dut8.g : dut.g) & ~mask);
    end
    c = b8 != 0 ? int'(count8) : int'(count);
    o = b8 != 0 ? int'(ovf8) : int'(ovf);
    live = b8 != 0 ? int'(ro_out8) : int'(ro_out);
  endtask

  initial begin
    int lat, c, o, bz, others, live, bad, n_done, first;
    vecs[0] = '{0, 0, 100, 500, 2, 0, 111};
    vecs[1] = '{0, 0, 60, 300, 2, 0, 71};
    vecs[2] = '{0, 1, 60, 200, 2, 0, 71};
    vecs[3] = '{0, 2, 60, 150, 2, 0, 71};
    vecs[4] = '{0, 3, 60, 120, 2, 0, 71};
    vecs[5] = '{1, 0, 100, 255, 0, 1, 111};
    vecs[6] = '{1, 0, 10, 50, 2, 0, 21};
    vecs[7] = '{0, 0, 0, 5, 2, 0, 12};
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || done || count != 16'd0 || ovf || ro_out || dut.g != 4'd0 || dut.en != 4'd0) bad++;
    end
    check("idle_after_reset", bad, 0, 0);
    foreach (vecs[i]) begin
      run(vecs[i].b8, vecs[i].s, vecs[i].w, lat, c, o, bz, others, live);
      check($sformatf("v%0d_busy", i), bz, 1, 0);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat, 0);
      check($sformatf("v%0d_count", i), c, vecs[i].cnt, vecs[i].tol);
      check($sformatf("v%0d_ovf", i), o, vecs[i].ovf, 0);
      check($sformatf("v%0d_other_rings", i), others, 0, 0);
      check($sformatf("v%0d_ro_out_stopped", i), live, 0, 0);
    end
    // second start during MEAS must be ignored
    @(negedge clk);
    sel = 2'd0;
    win_cycles = 12'd100;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    first = -1;
    lat = 0;
    repeat (250) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 20) start = 1'b1;
      if (lat == 21) start = 1'b0;
      if (done) begin
        n_done++;
        if (first < 0) first = lat;
      end
    end
    check("ignored_start_done_pulses", n_done, 1, 0);
    check("ignored_start_latency", first, 111, 0);
    check("ignored_start_busy_end", int'(busy), 0, 0);
    check("ignored_start_count", int'(count), 500, 2);
    // reset in the middle of a measurement
    @(negedge clk);
    sel = 2'd1;
    win_cycles = 12'd100;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #2000 rst = 1'b1;
    #1;
    check("rst_ro_out", int'(ro_out), 0, 0);
    check("rst_enables", int'(dut.en), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_counter", int'(dut.cnt), 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (150) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("rst_no_done", n_done, 0, 0);
    run(0, 1, 60, lat, c, o, bz, others, live);
    check("post_rst_latency", lat, 71, 0);
    check("post_rst_count", c, 200, 2);
    check("post_rst_ovf", o, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
